// File: rtl/trap_sequencer.sv
// Control FSM for the RV32IM core: mul/div wait, WFI sleep, interrupt entry and MRET return.
// Define TRAP_SEQ_WFI_TIMEOUT_EN to give WFI sleep a SLEEP_TO_CYCLES-cycle timeout.
module trap_sequencer #(
  parameter logic [3:0] INT_CODE0       = 4'd11,
  parameter logic [3:0] INT_CODE1       = 4'd7,
  parameter int         SLEEP_TO_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dec_valid,
  input  logic       dec_stall,
  input  logic       dec_intr_en,
  input  logic       int0,
  input  logic       int1,
  input  logic       is_muldiv,
  input  logic       is_wfi,
  input  logic       is_mret,
  input  logic       mul_rdy,
  input  logic       div_rdy,
  input  logic       csr_mie_we,
  input  logic       csr_mie_wdata,
  output logic [2:0] curr_state,
  output logic       muldiv_act,
  output logic       mstatus_we,
  output logic       mepc_we,
  output logic       pc_ld_mtvec,
  output logic       pc_ld_mepc,
  output logic       flush,
  output logic [1:0] int_ack,
  output logic       mie,
  output logic       mpie,
  output logic [3:0] mcause_code
);

  typedef enum logic [2:0] {
    INST          = 3'b000,
    MULDIV        = 3'b001,
    TRAP_MSTATUS  = 3'b010,
    TRAP_MEPC_SET = 3'b011,
    TRAP_MTVEC    = 3'b100,
    TRAP_MEPC_RET = 3'b101,
    TRAP_INT      = 3'b110,
    SLEEP         = 3'b111
  } state_t;

  state_t     state_reg, state_next;
  logic       mie_reg, mpie_reg;
  logic [3:0] cause_reg;
  logic       src_reg;          // 0 = int0, 1 = int1
  logic       sleep_timeout;

  wire take_int = dec_intr_en & mie_reg & (int0 | int1);
  wire dec_go   = dec_valid & ~dec_stall;

`ifdef TRAP_SEQ_WFI_TIMEOUT_EN
  localparam int CW = (SLEEP_TO_CYCLES > 1) ? $clog2(SLEEP_TO_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(SLEEP_TO_CYCLES - 1);
  logic [CW-1:0] sleep_cnt_reg;

  // Held at zero outside SLEEP, so every sleep starts counting from zero.
  always_ff @(posedge clk) begin
    if (rst || state_reg != SLEEP) begin
      sleep_cnt_reg <= '0;
    end else begin
      sleep_cnt_reg <= sleep_cnt_reg + 1'b1;
    end
  end

  assign sleep_timeout = (state_reg == SLEEP) && (sleep_cnt_reg == TO_LAST);
`else
  logic unused_cfg;
  assign unused_cfg    = ^SLEEP_TO_CYCLES;
  assign sleep_timeout = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      INST: begin
        if (take_int)                 state_next = TRAP_MSTATUS;
        else if (dec_go && is_muldiv) state_next = MULDIV;
        else if (dec_go && is_wfi)    state_next = SLEEP;
        else if (dec_go && is_mret)   state_next = TRAP_MEPC_RET;
      end
      MULDIV:        if (mul_rdy | div_rdy) state_next = INST;
      TRAP_MSTATUS:  state_next = TRAP_MEPC_SET;
      TRAP_MEPC_SET: state_next = TRAP_MTVEC;
      TRAP_MTVEC:    state_next = TRAP_INT;
      TRAP_INT:      state_next = INST;
      TRAP_MEPC_RET: state_next = INST;
      SLEEP:         if ((int0 | int1) || sleep_timeout) state_next = INST;
      default:       state_next = INST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= INST;
      mie_reg   <= 1'b0;
      mpie_reg  <= 1'b0;
      cause_reg <= 4'd0;
      src_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        INST: begin
          // A CSR write commits even when a trap is taken; TRAP_MSTATUS then clears mie.
          if (csr_mie_we) mie_reg <= csr_mie_wdata;
          if (take_int) begin
            src_reg   <= ~int0;
            cause_reg <= int0 ? INT_CODE0 : INT_CODE1;
          end
        end
        TRAP_MSTATUS: begin
          mpie_reg <= mie_reg;
          mie_reg  <= 1'b0;
        end
        TRAP_MEPC_RET: begin
          mie_reg  <= mpie_reg;
          mpie_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    muldiv_act  = 1'b0;
    mstatus_we  = 1'b0;
    mepc_we     = 1'b0;
    pc_ld_mtvec = 1'b0;
    pc_ld_mepc  = 1'b0;
    flush       = 1'b0;
    int_ack     = 2'b00;
    case (state_reg)
      MULDIV:        muldiv_act = 1'b1;
      TRAP_MSTATUS:  mstatus_we = 1'b1;
      TRAP_MEPC_SET: mepc_we    = 1'b1;
      TRAP_MTVEC: begin
        pc_ld_mtvec = 1'b1;
        flush       = 1'b1;
      end
      TRAP_MEPC_RET: begin
        mstatus_we = 1'b1;
        pc_ld_mepc = 1'b1;
        flush      = 1'b1;
      end
      TRAP_INT:      int_ack = src_reg ? 2'b10 : 2'b01;
      default: ;
    endcase
  end

  assign curr_state  = state_reg;
  assign mie         = mie_reg;
  assign mpie        = mpie_reg;
  assign mcause_code = cause_reg;

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Control FSM of the RV32IM core that produces the 3-bit `curr_state` consumed by the decode stall logic.
- Consumes the stall logic's outputs: `dec_intr_en`, `dec_stall` and the mul/div ready flags.
- Sequences multi-cycle ops (MULDIV), WFI sleep, interrupt entry (mstatus → mepc → mtvec → ack) and MRET return.
- Owns the mstatus MIE/MPIE bits and the latched interrupt cause code.

Parameters:
- INT_CODE0, 4'd11, mcause exception code reported for int0 (machine external).
- INT_CODE1, 4'd7, mcause exception code reported for int1 (machine timer).
- SLEEP_TO_CYCLES, 1024, WFI timeout in cycles; used only with the optional feature; must be ≥ 1.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- dec_valid  in  1  decode stage holds a valid instruction.
- dec_stall  in  1  decode stalled; instruction-triggered transitions suppressed.
- dec_intr_en  in  1  interrupt may be taken this cycle.
- int0  in  1  interrupt request 0, level; higher priority.
- int1  in  1  interrupt request 1, level.
- is_muldiv  in  1  decoded instruction is M-extension.
- is_wfi  in  1  decoded instruction is WFI.
- is_mret  in  1  decoded instruction is MRET.
- mul_rdy  in  1  multiplier result ready.
- div_rdy  in  1  divider result ready.
- csr_mie_we  in  1  CSR write to mstatus.MIE.
- csr_mie_wdata  in  1  new MIE value.
- curr_state  out  3  FSM state.
- muldiv_act  out  1  mul/div in progress.
- mstatus_we  out  1  mstatus update strobe.
- mepc_we  out  1  capture PC of interrupted instruction into mepc.
- pc_ld_mtvec  out  1  load PC from mtvec.
- pc_ld_mepc  out  1  load PC from mepc.
- flush  out  1  flush prefetch/decode.
- int_ack  out  2  one-hot acknowledge; bit0 = int0, bit1 = int1.
- mie  out  1  mstatus.MIE.
- mpie  out  1  mstatus.MPIE.
- mcause_code  out  4  latched cause code.

Behaviour:
- Encoding: INST=000, MULDIV=001, TRAP_MSTATUS=010, TRAP_MEPC_SET=011, TRAP_MTVEC=100, TRAP_MEPC_RET=101, TRAP_INT=110, SLEEP=111.
- Reset (rst=1 at the edge):
  - curr_state=INST, mie=0, mpie=0, mcause_code=0, internal source flag=0.
  - All strobes and int_ack=0 from the next cycle.
  - Reset mid-sequence aborts the sequence; no partial CSR effect beyond updates already committed.
- Strobe outputs are decoded combinationally from curr_state, so each is high exactly in its state (one cycle each):
  - muldiv_act: MULDIV.
  - mstatus_we: TRAP_MSTATUS and TRAP_MEPC_RET.
  - mepc_we: TRAP_MEPC_SET.
  - pc_ld_mtvec and flush: TRAP_MTVEC.
  - pc_ld_mepc and flush: TRAP_MEPC_RET.
  - int_ack: TRAP_INT, one-hot for the latched source.
- INST priority, highest first:
  1. dec_intr_en & mie & (int0|int1) → TRAP_MSTATUS. Latch source int0 if int0=1, else int1. mcause_code ← INT_CODE0/INT_CODE1.
  2. dec_valid & !dec_stall & is_muldiv → MULDIV.
  3. dec_valid & !dec_stall & is_wfi → SLEEP.
  4. dec_valid & !dec_stall & is_mret → TRAP_MEPC_RET.
  5. Otherwise stay in INST.
- mie evaluation in INST: the interrupt decision uses the current (pre-write) mie. csr_mie_we in INST updates mie at the edge even if a trap is also taken; the trap entry then overwrites mie in TRAP_MSTATUS.
- csr_mie_we in any other state: ignored.
- MULDIV: stay until mul_rdy|div_rdy, then → INST. Interrupts are not taken.
- TRAP_MSTATUS: mpie ← mie, mie ← 0; → TRAP_MEPC_SET.
- TRAP_MEPC_SET → TRAP_MTVEC → TRAP_INT → INST, unconditional, one cycle each. Interrupt entry is 4 cycles.
- TRAP_MEPC_RET: mie ← mpie, mpie ← 1; → INST; 1 cycle.
- SLEEP: exit to INST on int0|int1, independent of mie. A level still pending with mie=1 is taken from INST on a later cycle via dec_intr_en.
- int0 and int1 together: int0 wins. int1 stays pending (level-triggered) and is taken after return.

Optional Feature:
- Macro: TRAP_SEQ_WFI_TIMEOUT_EN.
- Defined:
  - A counter clears on SLEEP entry and increments each SLEEP cycle.
  - On reaching SLEEP_TO_CYCLES-1 without an interrupt → INST, so sleep lasts exactly SLEEP_TO_CYCLES cycles.
  - Counter is cleared by rst.
- Undefined: no counter; SLEEP exits only on an interrupt.

Test Plan:
1. Reset, then dec_valid=1, is_muldiv=1, dec_stall=0 → curr_state=001 next cycle. muldiv_act=1 for 3 cycles; mul_rdy at cycle 3 → curr_state=000 the cycle after.
2. csr_mie_we=1/wdata=1 in INST, then int1=1, dec_intr_en=1 → states 010, 011, 100, 110, 000 on consecutive cycles. mie=0, mpie=1, mcause_code=7; int_ack=2'b10 for exactly 1 cycle; pc_ld_mtvec=flush=1 in state 100.
3. int0=int1=1 with mie=1 → mcause_code=11, int_ack=2'b01. Hold int1, execute MRET → state 101 (mie→1), then int1 taken: int_ack=2'b10.
4. WFI with mie=0 → curr_state=111 persists for 50 cycles; int0=1 → 000 next cycle; no trap taken.
5. rst=1 while in TRAP_MEPC_SET → next cycle curr_state=000, mie=0, mpie=0, all strobes 0, int_ack=0.
6. With TRAP_SEQ_WFI_TIMEOUT_EN and SLEEP_TO_CYCLES=8, WFI and no interrupt → curr_state=111 for exactly 8 cycles, then 000.
